branch_predictor_bht: RTL
=========================

Name: branch_predictor_bht

Overview:
- Dynamic branch predictor for the 5-stage pipeline.
- Keeps a direct-mapped table of 2-bit saturating counters, indexed by PC.
- Supplies the taken/not-taken prediction for a branch in ID.
- Trains the indexed counter when the branch resolves in EX, and keeps saturating branch and mispredict statistics counters.
- Its prediction travels down the pipeline as the branch prediction signal that the EX-stage misprediction check compares against the resolved outcome.

Parameters:
- IDX_W, 4, index width; table depth ENTRIES = 2**IDX_W.
- INIT_STATE, 2'b11, reset value of every counter (strongly taken).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- branch_id_i  input  1  the instruction in ID is a conditional branch.
- pc_id_i  input  32  PC of the instruction in ID.
- predict_taken_o  output  1  prediction for the ID branch; combinational.
- update_en_i  input  1  a branch is resolving in EX this cycle.
- pc_exe_i  input  32  PC of the resolving branch.
- taken_exe_i  input  1  resolved outcome, 1 = taken.
- pred_exe_i  input  1  the prediction that was issued for this branch.
- stall_i  input  1  load-use stall; an update is still applied (EX holds a valid bubble-free branch only when update_en_i=1).
- branch_cnt_o  output  CNT_W  number of resolved branches.
- mispredict_cnt_o  output  CNT_W  number of resolved branches whose outcome differed from the prediction.

Behaviour:
- Index: idx = pc[IDX_W+1:2]; PC bits [1:0] are ignored.
- Table: ENTRIES x 2-bit counters. States: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup:
  - predict_taken_o = branch_id_i & table[idx(pc_id_i)][1].
  - Pure combinational read, zero latency.
  - predict_taken_o = 0 whenever branch_id_i = 0.
- Update, on a rising edge with update_en_i = 1:
  - taken_exe_i = 1: the counter at idx(pc_exe_i) increments, saturating at 11.
  - taken_exe_i = 0: the counter decrements, saturating at 00.
  - No table change when update_en_i = 0.
- Same index read and written in one cycle: the lookup returns the pre-update value. There is no write-to-read bypass; the new value is visible from the next cycle.
- Aliasing: different PCs with equal idx share one counter. No tags.
- Statistics, on a rising edge with update_en_i = 1:
  - branch_cnt_o increments by 1.
  - mispredict_cnt_o increments by 1 iff pred_exe_i != taken_exe_i.
  - Both counters saturate at all-ones and never wrap.
  - mispredict_cnt_o <= branch_cnt_o always holds.
- stall_i does not gate the lookup or the update. The update path depends only on update_en_i, because the pipeline guarantees update_en_i = 0 for an EX bubble.
- Reset, asserted at any time including mid-update:
  - Immediately and asynchronously, all table entries = INIT_STATE and both statistics counters = 0.
  - predict_taken_o then follows branch_id_i & INIT_STATE[1].
  - The first edge after rst_i deasserts performs a normal update.
- X-safety: pc_id_i is don't-care when branch_id_i = 0. pc_exe_i, taken_exe_i and pred_exe_i are don't-care when update_en_i = 0.

Test Plan:
- Reset: assert rst_i mid-cycle, with no clock edge -> table reads 11 at all 16 indices; with branch_id_i = 1, predict_taken_o = 1 for pc_id_i = 0x00..0x3C; both counters = 0.
- Saturating training: 4 updates at pc_exe_i = 0x10, taken = 0 -> states 10, 01, 00, 00; predict at pc_id_i = 0x10 gives 1, then 0, 0, 0 after each edge. Then 2 taken updates -> 01, 10, and the prediction returns to 1.
- Aliasing / no-bypass: train 0x04 to 00; pc 0x44 (same idx 1) predicts 0. Same-cycle lookup of 0x04 while updating 0x04 taken from 01 -> this cycle predicts 0, next cycle predicts 1.
- Statistics: 10 updates with pred/taken pairs (1,1)x6 and (1,0)x4 -> branch_cnt_o = 10, mispredict_cnt_o = 4. Preload to 0xFFFE and apply 3 updates -> stays 0xFFFF.
- Gating: update_en_i = 0 with arbitrary pc/taken for 20 cycles, including stall_i = 1 -> table and counters unchanged; branch_id_i = 0 -> predict_taken_o = 0.
- Reset mid-operation: after training several entries, pulse rst_i between edges -> outputs return to reset values without a clock edge; the next update acts on INIT_STATE.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped 2-bit saturating-counter branch history table with statistics
module branch_predictor_bht #(
    parameter int         IDX_W      = 4,
    parameter logic [1:0] INIT_STATE = 2'b11,
    parameter int         CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_id_i,
    input  logic [31:0]      pc_id_i,
    output logic             predict_taken_o,
    input  logic             update_en_i,
    input  logic [31:0]      pc_exe_i,
    input  logic             taken_exe_i,
    input  logic             pred_exe_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0]       bht_q [ENTRIES];
    logic [IDX_W-1:0] idx_id;
    logic [IDX_W-1:0] idx_exe;
    logic [1:0]       cur_exe;
    logic [1:0]       nxt_exe;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;

    // Word-aligned PCs: the two low bits never distinguish branches.
    assign idx_id  = pc_id_i[IDX_W+1:2];
    assign idx_exe = pc_exe_i[IDX_W+1:2];

    // Stall does not gate anything; EX bubbles already arrive with update_en_i low.
    logic unused_bits;
    assign unused_bits = ^{stall_i, pc_id_i[31:IDX_W+2], pc_id_i[1:0],
                           pc_exe_i[31:IDX_W+2], pc_exe_i[1:0]};

    // Lookup reads the registered table directly, so a same-cycle update is not bypassed.
    assign predict_taken_o = branch_id_i & bht_q[idx_id][1];

    assign cur_exe = bht_q[idx_exe];

    // Saturating step of the counter being trained.
    always_comb begin
        nxt_exe = cur_exe;
        if (taken_exe_i) begin
            if (cur_exe != 2'b11) nxt_exe = cur_exe + 2'd1;
        end else begin
            if (cur_exe != 2'b00) nxt_exe = cur_exe - 2'd1;
        end
    end

    // Pattern table: asynchronous restore to INIT_STATE, trained on resolved branches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= INIT_STATE;
        end else if (update_en_i) begin
            bht_q[idx_exe] <= nxt_exe;
        end
    end

    // Saturating statistics; mispredicts only count alongside a branch, so they never exceed it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (update_en_i) begin
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if ((pred_exe_i != taken_exe_i) && (mispredict_cnt_q != '1))
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
endmodule
